// File: rtl/aq_djpeg_pkg.sv
// Shared constants for the DJPEG front end: buffer geometry and consume widths.
package aq_djpeg_pkg;

    localparam int unsigned BufW    = 64;
    localparam int unsigned LevelW  = 7;
    localparam int unsigned WordW   = 32;
    localparam int unsigned ByteUse = 8;
    localparam int unsigned WordUse = 16;

    // Reverse byte order of a 32-bit bus word.
    function automatic logic [31:0] byteSwap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aq_djpeg_fetch.sv
// 64-bit MSB-aligned bit buffer feeding the JPEG header parser.
// Optional AQ_DJPEG_FETCH_BSWAP_EN: treat InData[7:0] as the first stream byte.
module aq_djpeg_fetch
    import aq_djpeg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              InEnable,
    input  logic [WordW-1:0]  InData,
    output logic              InReady,
    output logic              DataInEnable,
    output logic [WordW-1:0]  DataIn,
    input  logic              UseByte,
    input  logic              UseWord,
    output logic [LevelW-1:0] Level
);

    logic [BufW-1:0]   Buf;
    logic [BufW-1:0]   bufNext;
    logic [BufW-1:0]   shifted;
    logic [BufW-1:0]   placed;
    logic [LevelW-1:0] levelNext;
    logic [LevelW-1:0] consume;
    logic [LevelW-1:0] base;
    logic [WordW-1:0]  word;
    logic              load;

`ifdef AQ_DJPEG_FETCH_BSWAP_EN
    assign word = byteSwap32(InData);
`else
    assign word = InData;
`endif

    assign DataIn       = Buf[BufW-1 -: WordW];
    assign DataInEnable = (Level >= LevelW'(WordW));
    assign InReady      = (Level <= LevelW'(WordW));
    assign load         = InEnable & InReady;

    // Shift out consumed bits and drop a new word right below the surviving window.
    always_comb begin
        consume = '0;
        if (DataInEnable) begin
            if (UseWord)
                consume = LevelW'(WordUse);
            else if (UseByte)
                consume = LevelW'(ByteUse);
        end
        base      = Level - consume;
        shifted   = Buf << consume;
        placed    = {word, {(BufW-WordW){1'b0}}} >> base;
        bufNext   = load ? (shifted | placed) : shifted;
        levelNext = base + (load ? LevelW'(WordW) : LevelW'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Buf   <= '0;
            Level <= '0;
        end else begin
            Buf   <= bufNext;
            Level <= levelNext;
        end
    end

endmodule

// File: tb/tb_aq_djpeg_fetch.sv
// Bench for aq_djpeg_fetch: byte-queue model checked every cycle plus directed literals.
module tb_aq_djpeg_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        InEnable;
    logic [31:0] InData;
    logic        InReady;
    logic        DataInEnable;
    logic [31:0] DataIn;
    logic        UseByte;
    logic        UseWord;
    logic [6:0]  Level;

    int tests = 0;
    int fails = 0;
    bit modelValid = 1'b0;
    logic [7:0] mq[$];

    aq_djpeg_fetch dut (
        .clk(clk), .rst(rst), .InEnable(InEnable), .InData(InData),
        .InReady(InReady), .DataInEnable(DataInEnable), .DataIn(DataIn),
        .UseByte(UseByte), .UseWord(UseWord), .Level(Level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream word as it must appear on the bus for the current build.
    function automatic logic [31:0] toBus(input logic [31:0] s);
`ifdef AQ_DJPEG_FETCH_BSWAP_EN
        return {s[7:0], s[15:8], s[23:16], s[31:24]};
`else
        return s;
`endif
    endfunction

    // Model: the buffer is just a FIFO of stream bytes.
    always @(posedge clk) begin
        int sz;
        int nc;
        logic [31:0] s;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            modelValid <= 1'b1;
        end else if (modelValid) begin
            nc = (sz >= 4) ? (UseWord ? 2 : (UseByte ? 1 : 0)) : 0;
            for (int i = 0; i < nc; i++) void'(mq.pop_front());
            if (InEnable && sz <= 4) begin
`ifdef AQ_DJPEG_FETCH_BSWAP_EN
                s = {InData[7:0], InData[15:8], InData[23:16], InData[31:24]};
`else
                s = InData;
`endif
                mq.push_back(s[31:24]); mq.push_back(s[23:16]);
                mq.push_back(s[15:8]);  mq.push_back(s[7:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (modelValid && !rst) begin
            e = '0;
            for (int i = 0; i < 4; i++)
                if (i < mq.size()) e[31-8*i -: 8] = mq[i];
            check("model_Level", {25'd0, Level}, 32'(8 * mq.size()));
            check("model_DataInEnable", {31'd0, DataInEnable}, {31'd0, mq.size() >= 4});
            check("model_InReady", {31'd0, InReady}, {31'd0, mq.size() <= 4});
            check("model_DataIn", DataIn, e);
        end
    end

    task automatic step(input logic en, input logic [31:0] d, input logic ub, input logic uw);
        InEnable = en; InData = d; UseByte = ub; UseWord = uw;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] nextByte;
        logic [7:0] ctr;
        int         loads;
        rst = 1'b1; InEnable = 0; InData = 0; UseByte = 0; UseWord = 0;
        @(posedge clk); #1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        check("reset_Level", {25'd0, Level}, 32'd0);
        check("reset_InReady", {31'd0, InReady}, 32'd1);
        check("reset_DataInEnable", {31'd0, DataInEnable}, 32'd0);
        check("reset_DataIn", DataIn, 32'h0);

        step(1, toBus(32'hFFD8FFE0), 0, 0);
        check("first_DataIn", DataIn, 32'hFFD8FFE0);
        check("first_DataInEnable", {31'd0, DataInEnable}, 32'd1);
        check("first_Level", {25'd0, Level}, 32'd32);
        check("first_InReady", {31'd0, InReady}, 32'd1);

        step(1, toBus(32'h00104A46), 0, 1);
        check("loadconsume_DataIn", DataIn, 32'hFFE00010);
        check("loadconsume_Level", {25'd0, Level}, 32'd48);
        check("loadconsume_InReady", {31'd0, InReady}, 32'd0);

        step(0, 0, 0, 1);
        check("word_DataIn", DataIn, 32'h00104A46);
        step(0, 0, 1, 1);
        check("both_Level", {25'd0, Level}, 32'd16);
        check("both_DataIn", DataIn, 32'h4A460000);

        step(0, 0, 1, 0);
        check("starved_Level", {25'd0, Level}, 32'd16);
        check("starved_DataIn", DataIn, 32'h4A460000);

        // Fill to 64 with an incrementing byte stream, then drain a byte per cycle.
        rst = 1'b1; step(0, 0, 0, 0); rst = 1'b0;
        ctr = 8'h01;
        step(1, toBus({ctr, ctr + 8'd1, ctr + 8'd2, ctr + 8'd3}), 0, 0); ctr += 8'd4;
        step(1, toBus({ctr, ctr + 8'd1, ctr + 8'd2, ctr + 8'd3}), 0, 0); ctr += 8'd4;
        check("full_Level", {25'd0, Level}, 32'd64);
        check("full_InReady", {31'd0, InReady}, 32'd0);
        nextByte = 8'h01;
        loads = 0;
        for (int c = 0; c < 48; c++) begin
            if (DataInEnable) begin
                check("order_byte", {24'd0, DataIn[31:24]}, {24'd0, nextByte});
                nextByte += 8'd1;
            end
            if (mq.size() <= 4) loads++;
            step(1, toBus({ctr, ctr + 8'd1, ctr + 8'd2, ctr + 8'd3}), 1, 0);
            if (loads * 4 + 9 > int'(ctr)) ctr += 8'd4;
        end
        check("order_count", {24'd0, nextByte}, 32'd49);

        // Reset mid-stream with a word offered: nothing may be accepted.
        rst = 1'b1;
        step(1, toBus(32'hDEADBEEF), 0, 0);
        check("midreset_Level", {25'd0, Level}, 32'd0);
        check("midreset_DataIn", DataIn, 32'h0);
        rst = 1'b0;
        step(0, 0, 0, 0);
        check("midreset_idle_Level", {25'd0, Level}, 32'd0);

`ifdef AQ_DJPEG_FETCH_BSWAP_EN
        step(1, 32'hE0FFD8FF, 0, 0);
        check("bswap_DataIn", DataIn, 32'hFFD8FFE0);
        rst = 1'b1; step(0, 0, 0, 0); rst = 1'b0;
        check("bswap_reset_Level", {25'd0, Level}, 32'd0);
`endif

        step(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
